ipsxe_fft_result_chk: RTL
=========================

# ipsxe_fft_result_chk

Result checker for the FFT on-board self-test. It consumes the FFT core's output AXI4-Stream and reads the golden spectrum from an expected-data ROM in lock-step. It compares each sample within a tolerance, checks frame framing, and reports the sticky `o_err` and `o_chk_finished` flags that the on-board top exports to its pins and simulation bench. It is the receiving/verdict end of the self-test, paired with the stimulus generator that feeds the FFT input.

## Interface
- `DATA_WIDTH`, 16: width of each real/imag component, signed two's complement.
- `FFT_LEN_LOG2`, 8: log2 of samples per frame (N = 256).
- `FRAME_NUM`, 4: frames to check per test run.
- `TOL`, 2: maximum allowed |dut − exp| per component, unsigned.
- `TIMEOUT_CYC`, 65535: idle cycles allowed in RUN with no valid sample.

Ports:
- `i_clk` in 1: single clock.
- `i_rstn` in 1: asynchronous active-low reset.
- `i_start_test` in 1: level input; its rising edge starts or restarts a run.
- `i_axi4s_data_tvalid` in 1: FFT output valid. There is no tready; the stream cannot be back-pressured.
- `i_axi4s_data_tdata` in 2*DATA_WIDTH: [DW-1:0] is real, [2DW-1:DW] is imag.
- `i_axi4s_data_tlast` in 1: last sample of frame.
- `o_exp_rd_en` out 1: ROM read enable (combinational).
- `o_exp_addr` out FFT_LEN_LOG2: ROM address = sample index within frame (combinational).
- `i_exp_data` in 2*DATA_WIDTH: ROM data, valid one cycle after the read (registered-output ROM). Same packing as tdata.
- `o_err` out 1: sticky error.
- `o_chk_finished` out 1: sticky run complete.
- `o_timeout` out 1: sticky, set when the run ended by watchdog.

## Operation
- States:
  - IDLE: after reset.
  - RUN: samples are checked.
  - DONE: holds the verdict.
- Start detect: `i_start_test` is registered once. A start pulse is prev=0, cur=1.
- Start pulse in any state moves to RUN and clears `o_err`, `o_chk_finished`, `o_timeout`, the sample index, the frame counter, the watchdog, and the pipeline valid bit.
- Accept = RUN && tvalid.
  - On accept: `o_exp_rd_en`=1, `o_exp_addr`=idx, tdata and tlast are registered into stage 1, and idx increments, wrapping N−1→0.
  - When idx wraps, the frame counter increments.
- Outside RUN:
  - tvalid is ignored.
  - `o_exp_rd_en`=0 and `o_exp_addr`=0.
- Stage 1 compare (combinational on stage-1 regs and `i_exp_data`):
  - Per component, diff = sign-extended (DW+1)-bit subtraction; take |diff| in DW+1 bits.
  - Mismatch if |diff| > TOL for real or imag.
  - Framing error if tlast=1 at idx≠N−1, or tlast=0 at idx=N−1.
  - Any error sets `o_err` (sticky). Checking continues to the end of the run.
- Completion: when the stage-1 sample is idx N−1 of frame FRAME_NUM−1, the next state is DONE and `o_chk_finished` is set.
- Watchdog:
  - It counts cycles in RUN with tvalid=0 and resets on accept.
  - At TIMEOUT_CYC it sets `o_err`, `o_timeout`, and `o_chk_finished`, and moves to DONE.
- DONE holds all flags until reset or the next start pulse.

## Timing
- Reset values:
  - State = IDLE.
  - `o_err`, `o_chk_finished`, `o_timeout` = 0.
  - idx, frame count, watchdog = 0.
  - `o_exp_rd_en`=0 and `o_exp_addr`=0.
- Latency:
  - Sample accepted at edge E; ROM samples its address at E.
  - Compare is evaluated between E and E+1.
  - `o_err` and `o_chk_finished` update at E+1.
- Back-to-back valids are supported every cycle. The pipeline is fully streaming with no bubbles required.
- A start pulse registered at the same edge as a stage-1 compare takes priority. The in-flight result is discarded and does not set `o_err`.
- A start pulse in DONE moves to RUN at the next edge, and the flags clear at that same edge.
- Asynchronous reset mid-RUN clears everything immediately, and no flag glitches high afterwards.
- tvalid in IDLE or DONE never advances idx and never raises `o_err`.

## Test plan
- Reset 100 ns, start pulse, then 4 frames × 256 matching samples (tdata == ROM, tlast at idx 255) back-to-back → `o_chk_finished`=1 one cycle after the last accept; `o_err`=0; `o_timeout`=0.
- Same run, but frame 2 sample 17 real = exp+2 and imag = exp−2 → no error (within TOL). Then sample 18 real = exp+3 → `o_err`=1 at the next edge and stays 1. `o_chk_finished` still rises after frame 3's last sample.
- Framing errors: tlast asserted at idx 100 of frame 0 → `o_err`=1. Separately, tlast=0 at idx 255 → `o_err`=1.
- Start pulse, then no tvalid, with TIMEOUT_CYC=1000 → after 1000 cycles `o_err`=1, `o_timeout`=1, `o_chk_finished`=1.
- Failed run in DONE (`o_err`=1), then a new start pulse → flags clear on the next edge. A clean 4-frame run then ends with `o_err`=0 and `o_chk_finished`=1.
- Assert `i_rstn`=0 mid-frame 1 with tvalid streaming, and tvalid with bad data while IDLE → all outputs 0 immediately, and `o_err` stays 0 until a start pulse.

Source files
------------

// File: rtl/ipsxe_fft_result_chk.sv
// FFT self-test result checker: compares the FFT output stream against a
// registered-output golden ROM within a tolerance and reports sticky verdict flags.
module ipsxe_fft_result_chk #(
  parameter int DATA_WIDTH   = 16,
  parameter int FFT_LEN_LOG2 = 8,
  parameter int FRAME_NUM    = 4,
  parameter int TOL          = 2,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_start_test,
  input  logic                      i_axi4s_data_tvalid,
  input  logic [2*DATA_WIDTH-1:0]   i_axi4s_data_tdata,
  input  logic                      i_axi4s_data_tlast,
  output logic                      o_exp_rd_en,
  output logic [FFT_LEN_LOG2-1:0]   o_exp_addr,
  input  logic [2*DATA_WIDTH-1:0]   i_exp_data,
  output logic                      o_err,
  output logic                      o_chk_finished,
  output logic                      o_timeout
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = FFT_LEN_LOG2;
  localparam int FW = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic            start_q;
  logic            start_pulse;
  logic            accept;
  logic [AW-1:0]   idx;
  logic [FW-1:0]   frame_cnt;
  logic [WW-1:0]   wd_cnt;

  logic            s1_vld;
  logic [2*DW-1:0] s1_data;
  logic            s1_last;
  logic            s1_at_end;
  logic            s1_final;

  logic [DW:0]     abs_re;
  logic [DW:0]     abs_im;
  logic            s1_err;

  function automatic logic [DW:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    return d[DW] ? -d : d;
  endfunction

  assign start_pulse = i_start_test & ~start_q;
  assign accept      = (state == RUN) && i_axi4s_data_tvalid;
  assign o_exp_rd_en = accept;
  assign o_exp_addr  = accept ? idx : '0;

  always_comb begin
    abs_re = abs_diff(s1_data[DW-1:0],    i_exp_data[DW-1:0]);
    abs_im = abs_diff(s1_data[2*DW-1:DW], i_exp_data[2*DW-1:DW]);
    s1_err = (abs_re > (DW+1)'(TOL)) || (abs_im > (DW+1)'(TOL)) || (s1_last != s1_at_end);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      idx            <= '0;
      frame_cnt      <= '0;
      wd_cnt         <= '0;
      s1_vld         <= 1'b0;
      s1_data        <= '0;
      s1_last        <= 1'b0;
      s1_at_end      <= 1'b0;
      s1_final       <= 1'b0;
      o_err          <= 1'b0;
      o_chk_finished <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      start_q <= i_start_test;
      if (start_pulse) begin
        // a restart discards whatever sample is sitting in stage 1
        state          <= RUN;
        idx            <= '0;
        frame_cnt      <= '0;
        wd_cnt         <= '0;
        s1_vld         <= 1'b0;
        o_err          <= 1'b0;
        o_chk_finished <= 1'b0;
        o_timeout      <= 1'b0;
      end else begin
        s1_vld <= accept;
        if (accept) begin
          s1_data   <= i_axi4s_data_tdata;
          s1_last   <= i_axi4s_data_tlast;
          s1_at_end <= &idx;
          s1_final  <= (&idx) && (frame_cnt == FW'(FRAME_NUM - 1));
          idx       <= idx + AW'(1);
          if (&idx) begin
            frame_cnt <= frame_cnt + FW'(1);
          end
          wd_cnt <= '0;
        end
        if (state == RUN) begin
          if (s1_vld && s1_err) begin
            o_err <= 1'b1;
          end
          if (s1_vld && s1_final) begin
            state          <= DONE;
            o_chk_finished <= 1'b1;
          end else if (!i_axi4s_data_tvalid) begin
            if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
              state          <= DONE;
              o_err          <= 1'b1;
              o_timeout      <= 1'b1;
              o_chk_finished <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + WW'(1);
            end
          end
        end
      end
    end
  end

endmodule
